segre_cache_fill_ctrl: RTL and testbench
========================================

Name: segre_cache_fill_ctrl

Overview:
- Miss-side responder for the cache tag/data arrays.
- On a tag miss it fetches the whole line from main memory, beat by beat, and assembles it in a line buffer.
- It then presents the line for one cycle with data_from_mm_o and a victim lane index. The tag array and data array use these to install the line.
- It sits between the cache tag/data arrays and the main-memory read port. It holds the cache pipeline stalled via busy_o while a refill is outstanding.

Parameters:
- NUM_LANES, 4, number of cache lanes (lines); power of two.
- BYTES_PER_LANE, 16, line size in bytes; power of two, at least WORD_SIZE/8.
- Derived: ELEMS_PER_LANE = BYTES_PER_LANE/(WORD_SIZE/8).
- Derived: ADDR_BYTE_SIZE = $clog2(BYTES_PER_LANE).
- Derived: ADDR_INDEX_SIZE = $clog2(NUM_LANES).
- Derived: LANE_SIZE = WORD_SIZE*ELEMS_PER_LANE.
- WORD_SIZE comes from EPI_pkg.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- miss_i  in  1  tag array reports a miss for addr_i.
- addr_i  in  WORD_SIZE  address of the missing access.
- busy_o  out  1  refill in progress; the cache must not issue a new access.
- mm_rd_req_o  out  1  line read request to main memory.
- mm_addr_o  out  WORD_SIZE  line-aligned request address; low ADDR_BYTE_SIZE bits are zero.
- mm_gnt_i  in  1  memory accepts the request.
- mm_data_valid_i  in  1  one data beat valid this cycle.
- mm_data_i  in  WORD_SIZE  data beat.
- data_from_mm_o  out  1  one-cycle pulse; the fill line is valid.
- fill_addr_o  out  WORD_SIZE  line-aligned address of the filled line.
- fill_line_o  out  LANE_SIZE  assembled line.
- lru_index_o  out  ADDR_INDEX_SIZE  victim lane to overwrite.

Behaviour:
- Reset (synchronous, active-high). State=IDLE; all outputs 0; beat counter 0; victim pointer 0; line buffer 0. Reset takes priority over every other event, including mid-refill: the request drops the next cycle, captured beats are discarded, and no data_from_mm_o pulse is produced.
- FSM states: IDLE, REQ, DATA, FILL.
- IDLE:
  - busy_o=0.
  - If miss_i=1: latch the line-aligned address as addr_i with its low ADDR_BYTE_SIZE bits cleared, and go to REQ.
  - Beats arriving in IDLE are ignored.
- REQ:
  - mm_rd_req_o=1, busy_o=1, mm_addr_o=latched address.
  - mm_rd_req_o and mm_addr_o stay stable until mm_gnt_i=1.
  - On grant go to DATA and clear the beat counter.
  - Beats arriving in REQ, including the grant cycle, are ignored. Memory guarantees the first beat is at least one cycle after grant.
- DATA:
  - mm_rd_req_o=0, busy_o=1.
  - Each cycle with mm_data_valid_i=1, beat k is written to fill_line bits [k*WORD_SIZE +: WORD_SIZE] and the counter increments.
  - Gaps between beats are allowed.
  - On the beat where the counter equals ELEMS_PER_LANE-1, go to FILL.
- FILL (exactly 1 cycle):
  - data_from_mm_o=1, busy_o=1.
  - fill_addr_o, fill_line_o and lru_index_o are valid in the same cycle.
  - The victim pointer then increments, wrapping from NUM_LANES-1 to 0.
  - Next state is IDLE.
- lru_index_o always shows the current victim pointer. fill_addr_o and fill_line_o hold their last value outside FILL.
- miss_i while busy_o=1 is ignored and is not queued.
- A miss in the cycle IDLE is re-entered after FILL is accepted normally.
- Minimum latency from miss_i to data_from_mm_o, with grant in the first REQ cycle and back-to-back beats: 1 (REQ) + ELEMS_PER_LANE (DATA) + 1 (FILL) cycles after the miss cycle. That is 6 cycles with the defaults.
- All outputs are driven from registers or from state decode only; no combinational path from mm_* inputs to outputs.

Test Plan:
- Basic refill:
  - Stimulus: after reset, miss_i=1 with addr_i=0x0000_1234. Grant in the first REQ cycle. Beats 0xA0, 0xA1, 0xA2, 0xA3 back-to-back.
  - Response: mm_addr_o=0x0000_1230. data_from_mm_o pulses once, 6 cycles after the miss. fill_line_o=0x000000A3_000000A2_000000A1_000000A0. lru_index_o=0.
- Grant stall and gappy data:
  - Stimulus: hold mm_gnt_i=0 for 5 cycles; insert 2 idle cycles between beats 1 and 2.
  - Response: mm_rd_req_o and mm_addr_o stay stable for all 5 cycles. The line is assembled correctly. The pulse is delayed by exactly 7 cycles versus the basic case.
- Victim wrap:
  - Stimulus: five consecutive refills.
  - Response: lru_index_o at each fill = 0, 1, 2, 3, 0.
- Miss while busy:
  - Stimulus: pulse miss_i with addr_i=0x40 during DATA of a refill to 0x80.
  - Response: only one memory request (0x80) and one fill pulse; the second miss is dropped.
- Stray beats:
  - Stimulus: mm_data_valid_i=1 while in IDLE, and in the REQ grant cycle.
  - Response: no state change; the line buffer content of the next fill is unaffected.
- Reset mid-refill:
  - Stimulus: assert rst_i after 2 of 4 beats.
  - Response: next cycle busy_o=0, mm_rd_req_o=0, and no data_from_mm_o pulse. A following miss fills with lru_index_o=0 and contains only the new beats.

Source files
------------

// File: rtl/segre_cache_fill_ctrl.sv
// Cache miss refill controller: fetches a full line from main memory beat by
// beat, assembles it, and presents it for one cycle with the victim lane index.

package EPI_pkg;
  localparam int unsigned WORD_SIZE = 32;
endpackage

module segre_cache_fill_ctrl
  import EPI_pkg::*;
#(
  parameter  int unsigned NUM_LANES       = 4,
  parameter  int unsigned BYTES_PER_LANE  = 16,
  localparam int unsigned ELEMS_PER_LANE  = BYTES_PER_LANE / (WORD_SIZE / 8),
  localparam int unsigned ADDR_BYTE_SIZE  = $clog2(BYTES_PER_LANE),
  localparam int unsigned ADDR_INDEX_SIZE = $clog2(NUM_LANES),
  localparam int unsigned LANE_SIZE       = WORD_SIZE * ELEMS_PER_LANE
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       miss_i,
  input  logic [WORD_SIZE-1:0]       addr_i,
  output logic                       busy_o,
  output logic                       mm_rd_req_o,
  output logic [WORD_SIZE-1:0]       mm_addr_o,
  input  logic                       mm_gnt_i,
  input  logic                       mm_data_valid_i,
  input  logic [WORD_SIZE-1:0]       mm_data_i,
  output logic                       data_from_mm_o,
  output logic [WORD_SIZE-1:0]       fill_addr_o,
  output logic [LANE_SIZE-1:0]       fill_line_o,
  output logic [ADDR_INDEX_SIZE-1:0] lru_index_o
);

  localparam int unsigned CNT_W = (ELEMS_PER_LANE > 1) ? $clog2(ELEMS_PER_LANE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [WORD_SIZE-1:0]       line_addr_q;
  logic [CNT_W-1:0]           beat_cnt_q;
  logic [LANE_SIZE-1:0]       line_buf_q, line_buf_d;
  logic [LANE_SIZE-1:0]       fill_line_q;
  logic [WORD_SIZE-1:0]       fill_addr_q;
  logic [ADDR_INDEX_SIZE-1:0] victim_q;

  logic miss_accept;
  logic gnt_accept;
  logic beat_we;
  logic last_beat;

  assign miss_accept = (state_q == IDLE) && miss_i;
  assign gnt_accept  = (state_q == REQ) && mm_gnt_i;
  assign beat_we     = (state_q == DATA) && mm_data_valid_i;
  assign last_beat   = (beat_cnt_q == CNT_W'(ELEMS_PER_LANE - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; beats outside DATA never advance the FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_i) state_d = REQ;
      REQ:     if (mm_gnt_i) state_d = DATA;
      DATA:    if (mm_data_valid_i && last_beat) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Merge the incoming beat into its word slot of the line buffer
  always_comb begin
    line_buf_d = line_buf_q;
    if (beat_we) line_buf_d[32'(beat_cnt_q) * WORD_SIZE +: WORD_SIZE] = mm_data_i;
  end

  // Datapath: request address, beat counter, line assembly, fill outputs, victim pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_addr_q <= '0;
      beat_cnt_q  <= '0;
      line_buf_q  <= '0;
      fill_line_q <= '0;
      fill_addr_q <= '0;
      victim_q    <= '0;
    end else begin
      if (miss_accept)
        line_addr_q <= {addr_i[WORD_SIZE-1:ADDR_BYTE_SIZE], ADDR_BYTE_SIZE'(0)};
      if (gnt_accept)   beat_cnt_q <= '0;
      else if (beat_we) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      line_buf_q <= line_buf_d;
      // Load the fill outputs on the final beat so they are stable throughout FILL
      if (beat_we && last_beat) begin
        fill_line_q <= line_buf_d;
        fill_addr_q <= line_addr_q;
      end
      if (state_q == FILL) victim_q <= victim_q + ADDR_INDEX_SIZE'(1);
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign mm_rd_req_o    = (state_q == REQ);
  assign data_from_mm_o = (state_q == FILL);
  assign mm_addr_o      = line_addr_q;
  assign fill_addr_o    = fill_addr_q;
  assign fill_line_o    = fill_line_q;
  assign lru_index_o    = victim_q;

endmodule

// File: tb/tb_segre_cache_fill_ctrl.sv
// Testbench for segre_cache_fill_ctrl: directed and randomized refills checked
// against a transaction-level model (line address, beat list, victim rotation, latency).

module tb_segre_cache_fill_ctrl;

  localparam int unsigned WS    = 32;
  localparam int unsigned ELEMS = 4;
  localparam int unsigned LANES = 4;
  localparam int unsigned LINEB = 16;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            miss_i;
  logic [WS-1:0]   addr_i;
  logic            busy_o;
  logic            mm_rd_req_o;
  logic [WS-1:0]   mm_addr_o;
  logic            mm_gnt_i;
  logic            mm_data_valid_i;
  logic [WS-1:0]   mm_data_i;
  logic            data_from_mm_o;
  logic [WS-1:0]   fill_addr_o;
  logic [127:0]    fill_line_o;
  logic [1:0]      lru_index_o;

  int vectors     = 0;
  int miscompares = 0;
  int fills_done  = 0;

  logic [WS-1:0] beats [ELEMS];
  int            gaps  [ELEMS-1];

  segre_cache_fill_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .miss_i          (miss_i),
    .addr_i          (addr_i),
    .busy_o          (busy_o),
    .mm_rd_req_o     (mm_rd_req_o),
    .mm_addr_o       (mm_addr_o),
    .mm_gnt_i        (mm_gnt_i),
    .mm_data_valid_i (mm_data_valid_i),
    .mm_data_i       (mm_data_i),
    .data_from_mm_o  (data_from_mm_o),
    .fill_addr_o     (fill_addr_o),
    .fill_line_o     (fill_line_o),
    .lru_index_o     (lru_index_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One refill transaction; the bench sits at a negedge in IDLE on entry and exit.
  task automatic refill(input logic [WS-1:0] addr, input int gnt_dly,
                        input bit stray, input bit busy_miss);
    logic [WS-1:0]  exp_addr;
    logic [127:0]   exp_line;
    int             lat_exp;
    int             cyc;
    int             got;
    exp_addr = addr & ~WS'(LINEB - 1);
    exp_line = '0;
    lat_exp  = 1 + (gnt_dly + 1) + ELEMS + 1 - 1;
    for (int k = 0; k < ELEMS; k++) exp_line[k*WS +: WS] = beats[k];
    for (int k = 0; k < ELEMS - 1; k++) lat_exp += gaps[k];

    cyc = 0;
    chk("idle_busy", 128'(busy_o), 128'(0));
    miss_i = 1'b1;
    addr_i = addr;
    if (stray) begin
      mm_data_valid_i = 1'b1;
      mm_data_i       = $urandom;
    end
    step(); cyc++;
    miss_i          = 1'b0;
    mm_data_valid_i = 1'b0;
    addr_i          = $urandom;

    for (int g = 0; g <= gnt_dly; g++) begin
      chk("req_high", 128'(mm_rd_req_o), 128'(1));
      chk("req_addr", 128'(mm_addr_o), 128'(exp_addr));
      chk("req_busy", 128'(busy_o), 128'(1));
      mm_gnt_i = (g == gnt_dly);
      if (stray && g == gnt_dly) begin
        mm_data_valid_i = 1'b1;
        mm_data_i       = $urandom;
      end
      step(); cyc++;
      mm_data_valid_i = 1'b0;
    end
    mm_gnt_i = 1'b0;

    for (int k = 0; k < ELEMS; k++) begin
      chk("data_busy", 128'(busy_o), 128'(1));
      chk("data_noreq", 128'(mm_rd_req_o), 128'(0));
      chk("data_nopulse", 128'(data_from_mm_o), 128'(0));
      mm_data_valid_i = 1'b1;
      mm_data_i       = beats[k];
      if (busy_miss && k == 1) begin
        miss_i = 1'b1;
        addr_i = 32'h40;
      end
      step(); cyc++;
      miss_i          = 1'b0;
      mm_data_valid_i = 1'b0;
      mm_data_i       = $urandom;
      if (k < ELEMS - 1) begin
        for (int gp = 0; gp < gaps[k]; gp++) begin
          chk("gap_busy", 128'(busy_o), 128'(1));
          step(); cyc++;
        end
      end
    end

    got = -1;
    for (int w = 0; w < 32; w++) begin
      if (data_from_mm_o === 1'b1) begin
        got = cyc;
        break;
      end
      step(); cyc++;
    end
    chk("fill_latency", 128'(got), 128'(lat_exp));
    if (got >= 0) begin
      chk("fill_addr", 128'(fill_addr_o), 128'(exp_addr));
      chk("fill_line", fill_line_o, exp_line);
      chk("fill_lru", 128'(lru_index_o), 128'(fills_done % LANES));
      chk("fill_busy", 128'(busy_o), 128'(1));
      step();
    end
    fills_done++;
    chk("post_pulse", 128'(data_from_mm_o), 128'(0));
    chk("post_busy", 128'(busy_o), 128'(0));
    chk("post_line_hold", fill_line_o, exp_line);
    chk("post_lru", 128'(lru_index_o), 128'(fills_done % LANES));
    if (busy_miss) begin
      for (int i = 0; i < 3; i++) begin
        chk("dropped_miss_noreq", 128'(mm_rd_req_o), 128'(0));
        chk("dropped_miss_idle", 128'(busy_o), 128'(0));
        step();
      end
    end
  endtask

  task automatic rand_beats_gaps(input int gap_max);
    for (int k = 0; k < ELEMS; k++) beats[k] = $urandom;
    for (int k = 0; k < ELEMS - 1; k++) gaps[k] = $urandom_range(gap_max, 0);
  endtask

  initial begin
    rst_i = 1'b1; miss_i = 1'b0; addr_i = '0;
    mm_gnt_i = 1'b0; mm_data_valid_i = 1'b0; mm_data_i = '0;
    step(); step();

    // Reset values
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_req", 128'(mm_rd_req_o), 128'(0));
    chk("rst_mm_addr", 128'(mm_addr_o), 128'(0));
    chk("rst_pulse", 128'(data_from_mm_o), 128'(0));
    chk("rst_fill_addr", 128'(fill_addr_o), 128'(0));
    chk("rst_fill_line", fill_line_o, 128'(0));
    chk("rst_lru", 128'(lru_index_o), 128'(0));
    rst_i = 1'b0;
    step();

    // Basic refill
    for (int k = 0; k < ELEMS; k++) beats[k] = 32'hA0 + 32'(k);
    for (int k = 0; k < ELEMS - 1; k++) gaps[k] = 0;
    refill(32'h0000_1234, 0, 1'b0, 1'b0);

    // Grant stall of 5 cycles and two idle cycles between beats 1 and 2
    rand_beats_gaps(0);
    gaps[1] = 2;
    refill(32'h0000_5678, 5, 1'b0, 1'b0);

    // Three more to complete five consecutive fills and wrap the victim pointer
    for (int i = 0; i < 3; i++) begin
      rand_beats_gaps(2);
      refill($urandom, int'($urandom_range(3, 0)), 1'b0, 1'b0);
    end

    // Miss while busy is dropped
    rand_beats_gaps(1);
    refill(32'h80, 0, 1'b0, 1'b1);

    // Stray beats in IDLE and in the grant cycle
    rand_beats_gaps(1);
    refill($urandom, 2, 1'b1, 1'b0);

    // Reset after two of four beats
    miss_i = 1'b1; addr_i = 32'h0000_2220;
    step();
    miss_i = 1'b0; mm_gnt_i = 1'b1;
    step();
    mm_gnt_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mm_data_valid_i = 1'b1; mm_data_i = 32'hDEAD_0000 + 32'(k);
      step();
    end
    mm_data_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    fills_done = 0;
    chk("midrst_busy", 128'(busy_o), 128'(0));
    chk("midrst_req", 128'(mm_rd_req_o), 128'(0));
    chk("midrst_pulse", 128'(data_from_mm_o), 128'(0));
    chk("midrst_lru", 128'(lru_index_o), 128'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_pulse", 128'(data_from_mm_o), 128'(0));
    end
    rand_beats_gaps(0);
    refill(32'h0000_3330, 0, 1'b0, 1'b0);

    // Randomized refills
    for (int i = 0; i < 8; i++) begin
      rand_beats_gaps(3);
      refill($urandom, int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)), 1'b0);
      repeat ($urandom_range(2, 0)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
